prbs_gen_par: RTL and testbench

- Parametrised successor to the team's fixed single-bit PRBS9 generator.
- Runtime-selectable PRBS7/9/15/23/31 polynomial, NB bits emitted per advance, loadable seed with zero-lockup protection, single-bit error injection, and a free-running word counter.
- Feeds the transmit data path and BER test structures; serial bit order is identical to the single-bit generator, so existing PRBS9 checkers remain valid.

---
 rtl/prbs_gen_par.sv | 164 ++++++++++++++++
 tb/tb_prbs_gen_par.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen_par.sv
// prbs_gen_par: parallel PRBS generator with runtime-selectable polynomial.
//
// Emits NB bits of a PRBS7/9/15/23/31 sequence per advance request.
// o_data[NB-1] is the oldest serial bit, so a serial reading of o_data
// MSB-first reproduces the single-bit generator's bit stream.
//
// Ports:
//   clk         system clock
//   i_reset     synchronous active-high reset
//   i_en        enable; low reloads the LFSR from the stored seed and samples i_mode
//   i_ctrl      advance request; one NB-bit word per high cycle while enabled
//   i_mode      polynomial select (0..4 = PRBS7/9/15/23/31, 5..7 = PRBS9)
//   i_seed      seed value, masked to the active order
//   i_load      seed load strobe
//   i_inj_err   error-injection request (inverts MSB of the next emitted word)
//   o_data      emitted word
//   o_valid     o_data updated this cycle
//   o_seed_fix  sticky flag: an all-zero seed was replaced by all-ones
//   o_word_cnt  wrapping count of emitted words
//
// Handshake: o_valid is a one-cycle strobe qualifying o_data, asserted the
// cycle after an accepted i_ctrl. There is no ready/backpressure; a
// consumer must take the word in the cycle o_valid is high.
module prbs_gen_par #(
    parameter int          NB           = 8,
    parameter int          CNT_W        = 32,
    parameter logic [2:0]  DEFAULT_MODE = 3'd1,
    parameter logic [30:0] DEFAULT_SEED = 31'h7FFFFFFF
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_ctrl,
    input  logic [2:0]       i_mode,
    input  logic [30:0]      i_seed,
    input  logic             i_load,
    input  logic             i_inj_err,
    output logic [NB-1:0]    o_data,
    output logic             o_valid,
    output logic             o_seed_fix,
    output logic [CNT_W-1:0] o_word_cnt
);

    // Unused mode codes fall back to PRBS9.
    function automatic logic [2:0] norm_mode(input logic [2:0] m);
        return (m > 3'd4) ? 3'd1 : m;
    endfunction

    function automatic logic [4:0] order_of(input logic [2:0] m);
        case (m)
            3'd0:    return 5'd7;
            3'd2:    return 5'd15;
            3'd3:    return 5'd23;
            3'd4:    return 5'd31;
            default: return 5'd9;
        endcase
    endfunction

    function automatic logic [4:0] tap_of(input logic [2:0] m);
        case (m)
            3'd0:    return 5'd6;
            3'd2:    return 5'd14;
            3'd3:    return 5'd18;
            3'd4:    return 5'd28;
            default: return 5'd5;
        endcase
    endfunction

    function automatic logic [30:0] mask_of(input logic [2:0] m);
        return 31'h7FFFFFFF >> (5'd31 - order_of(m));
    endfunction

    function automatic logic seed_is_zero(input logic [30:0] s, input logic [2:0] m);
        return (s & mask_of(m)) == 31'd0;
    endfunction

    // Masked seed with all-zero replaced by all-ones of the active order,
    // since an all-zero LFSR never leaves the zero state.
    function automatic logic [30:0] fix_seed(input logic [30:0] s, input logic [2:0] m);
        return seed_is_zero(s, m) ? mask_of(m) : (s & mask_of(m));
    endfunction

    logic [30:0]   lfsr_q;
    logic [30:0]   seed_q;
    logic [2:0]    mode_q;
    logic          pend_q;

    logic [4:0]    ord_m1;
    logic [4:0]    tap_m1;
    logic [30:0]   act_mask;
    logic [30:0]   adv_r;
    logic [NB-1:0] adv_data;
    logic [NB-1:0] msb_mask;
    logic [2:0]    new_mode;
    logic          out_bit;
    logic          fb;

    assign ord_m1   = order_of(mode_q) - 5'd1;
    assign tap_m1   = tap_of(mode_q) - 5'd1;
    assign act_mask = mask_of(mode_q);
    assign new_mode = norm_mode(i_mode);

    always_comb begin
        msb_mask         = '0;
        msb_mask[NB-1]   = 1'b1;
    end

    // NB serial steps unrolled into one cycle.
    always_comb begin
        adv_r    = lfsr_q;
        adv_data = '0;
        out_bit  = 1'b0;
        fb       = 1'b0;
        for (int k = 0; k < NB; k++) begin
            out_bit            = adv_r[ord_m1];
            fb                 = out_bit ^ adv_r[tap_m1];
            adv_data[NB-1-k]   = out_bit;
            adv_r              = ((adv_r << 1) | {30'd0, fb}) & act_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            mode_q     <= norm_mode(DEFAULT_MODE);
            seed_q     <= fix_seed(DEFAULT_SEED, norm_mode(DEFAULT_MODE));
            lfsr_q     <= fix_seed(DEFAULT_SEED, norm_mode(DEFAULT_MODE));
            pend_q     <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_seed_fix <= 1'b0;
            o_word_cnt <= '0;
        end else if (!i_en) begin
            // Disabled: sample mode, reload LFSR from (possibly new) seed.
            mode_q  <= new_mode;
            pend_q  <= 1'b0;
            o_valid <= 1'b0;
            if (i_load) begin
                seed_q <= i_seed & mask_of(new_mode);
                lfsr_q <= fix_seed(i_seed, new_mode);
                if (seed_is_zero(i_seed, new_mode)) o_seed_fix <= 1'b1;
            end else begin
                lfsr_q <= fix_seed(seed_q, new_mode);
                if (seed_is_zero(seed_q, new_mode)) o_seed_fix <= 1'b1;
            end
        end else if (i_load) begin
            seed_q  <= i_seed & act_mask;
            lfsr_q  <= fix_seed(i_seed, mode_q);
            if (seed_is_zero(i_seed, mode_q)) o_seed_fix <= 1'b1;
            pend_q  <= pend_q | i_inj_err;
            o_valid <= 1'b0;
        end else if (i_ctrl) begin
            // Injection corrupts only the output word, never the LFSR.
            lfsr_q     <= adv_r;
            o_data     <= (pend_q | i_inj_err) ? (adv_data ^ msb_mask) : adv_data;
            pend_q     <= 1'b0;
            o_valid    <= 1'b1;
            o_word_cnt <= o_word_cnt + CNT_W'(1);
        end else begin
            pend_q  <= pend_q | i_inj_err;
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prbs_gen_par.sv
// tb_prbs_gen_par: directed self-checking bench for prbs_gen_par.
// Three instances share control inputs: dut8 (NB=8), dut1 (NB=1, own advance
// strobe) and dut_c4 (NB=8, CNT_W=4) for counter wrap.
module tb_prbs_gen_par;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_en = 1'b0;
    logic        ctrl8 = 1'b0;
    logic        ctrl1 = 1'b0;
    logic [2:0]  i_mode = 3'd1;
    logic [30:0] i_seed = 31'd0;
    logic        i_load = 1'b0;
    logic        i_inj_err = 1'b0;

    logic [7:0]  d8_data;
    logic        d8_valid, d8_fix;
    logic [31:0] d8_cnt;
    logic [0:0]  d1_data;
    logic        d1_valid, d1_fix;
    logic [31:0] d1_cnt;
    logic [7:0]  c4_data;
    logic        c4_valid, c4_fix;
    logic [3:0]  c4_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_q[$];
    logic        exp_bits[512];
    logic        obs_bits[512];

    // Independent serial reference model state.
    logic [30:0] m_r;
    logic [2:0]  m_mode;

    always #5 clk = ~clk;

    prbs_gen_par #(.NB(8), .CNT_W(32)) dut8 (
        .clk(clk), .i_reset(i_reset), .i_en(i_en), .i_ctrl(ctrl8),
        .i_mode(i_mode), .i_seed(i_seed), .i_load(i_load), .i_inj_err(i_inj_err),
        .o_data(d8_data), .o_valid(d8_valid), .o_seed_fix(d8_fix), .o_word_cnt(d8_cnt)
    );

    prbs_gen_par #(.NB(1), .CNT_W(32)) dut1 (
        .clk(clk), .i_reset(i_reset), .i_en(i_en), .i_ctrl(ctrl1),
        .i_mode(i_mode), .i_seed(i_seed), .i_load(i_load), .i_inj_err(i_inj_err),
        .o_data(d1_data), .o_valid(d1_valid), .o_seed_fix(d1_fix), .o_word_cnt(d1_cnt)
    );

    prbs_gen_par #(.NB(8), .CNT_W(4)) dut_c4 (
        .clk(clk), .i_reset(i_reset), .i_en(i_en), .i_ctrl(ctrl8),
        .i_mode(i_mode), .i_seed(i_seed), .i_load(i_load), .i_inj_err(i_inj_err),
        .o_data(c4_data), .o_valid(c4_valid), .o_seed_fix(c4_fix), .o_word_cnt(c4_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial reference: one bit per step, taps from the polynomial table.
    task automatic model_bit(output logic b);
        int l, t;
        case (m_mode)
            3'd0: begin l = 7;  t = 6;  end
            3'd2: begin l = 15; t = 14; end
            3'd3: begin l = 23; t = 18; end
            3'd4: begin l = 31; t = 28; end
            default: begin l = 9; t = 5; end
        endcase
        b   = m_r[l-1];
        m_r = {m_r[29:0], m_r[l-1] ^ m_r[t-1]} & ((31'h7FFFFFFF) >> (31 - l));
    endtask

    task automatic model_word(output logic [7:0] w);
        logic b;
        for (int k = 7; k >= 0; k--) begin
            model_bit(b);
            w[k] = b;
        end
    endtask

    initial begin
        logic [7:0]  w;
        logic [31:0] obs_chunk, exp_chunk;

        // Reset state.
        i_reset = 1'b1;
        tick();
        check("rst_data", {24'd0, d8_data}, 32'd0);
        check("rst_valid", {31'd0, d8_valid}, 32'd0);
        check("rst_cnt", d8_cnt, 32'd0);
        check("rst_fix", {31'd0, d8_fix}, 32'd0);

        // First two words from default PRBS9 all-ones seed.
        i_reset = 1'b0; i_en = 1'b1; i_mode = 3'd1; ctrl8 = 1'b1;
        tick();
        check("w0_valid", {31'd0, d8_valid}, 32'd1);
        check("w0_data", {24'd0, d8_data}, 32'h0000_00FF);
        tick();
        ctrl8 = 1'b0;
        check("w1_data", {24'd0, d8_data}, 32'h0000_0083);
        check("w1_cnt", d8_cnt, 32'd2);
        tick();
        check("idle_valid", {31'd0, d8_valid}, 32'd0);
        check("idle_hold", {24'd0, d8_data}, 32'h0000_0083);
        check("idle_cnt", d8_cnt, 32'd2);

        // Reload from stored seed, then NB=1 and NB=8 streams in parallel.
        i_en = 1'b0;
        tick();
        i_en = 1'b1;
        m_r = 31'h1FF; m_mode = 3'd1;
        for (int i = 0; i < 512; i++) model_bit(exp_bits[i]);
        for (int j = 0; j < 64; j++) begin
            for (int k = 0; k < 8; k++) w[7-k] = exp_bits[8*j+k];
            exp_q.push_back(w);
        end
        for (int i = 0; i < 512; i++) begin
            ctrl1 = 1'b1;
            ctrl8 = (i < 64);
            tick();
            obs_bits[i] = d1_data[0];
            if (d8_valid) begin
                if (exp_q.size() == 0) check("stream8_extra", 32'd1, 32'd0);
                else check("stream8_word", {24'd0, d8_data}, {24'd0, exp_q.pop_front()});
            end
        end
        ctrl1 = 1'b0; ctrl8 = 1'b0;
        tick();
        check("stream8_left", exp_q.size(), 32'd0);
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 32; k++) begin
                obs_chunk[31-k] = obs_bits[32*c+k];
                exp_chunk[31-k] = exp_bits[32*c+k];
            end
            check("stream1_chunk", obs_chunk, exp_chunk);
        end
        check("stream1_repeat", {31'd0, obs_bits[511]}, {31'd0, exp_bits[0]});
        check("stream1_cnt", d1_cnt, 32'd512);
        check("stream8_cnt", d8_cnt, 32'd66);

        // Zero seed in PRBS7 -> all-ones, sticky fix flag.
        i_en = 1'b0; i_mode = 3'd0;
        tick();
        i_en = 1'b1; i_load = 1'b1; i_seed = 31'd0; ctrl8 = 1'b1;
        tick();
        i_load = 1'b0;
        check("load_valid", {31'd0, d8_valid}, 32'd0);
        check("load_fix", {31'd0, d8_fix}, 32'd1);
        tick();
        ctrl8 = 1'b0;
        check("p7_fix_word", {24'd0, d8_data}, 32'h0000_00FE);
        i_load = 1'b1; i_seed = 31'h55;
        tick();
        i_load = 1'b0;
        check("fix_sticky", {31'd0, d8_fix}, 32'd1);
        ctrl8 = 1'b1;
        tick();
        ctrl8 = 1'b0;
        check("p7_55_word", {24'd0, d8_data}, 32'h0000_00AB);
        m_r = 31'h55; m_mode = 3'd0;
        model_word(w);

        // Two injection requests while idle collapse into one.
        i_inj_err = 1'b1; tick();
        i_inj_err = 1'b0; tick();
        i_inj_err = 1'b1; tick();
        i_inj_err = 1'b0; tick();
        check("inj_idle_valid", {31'd0, d8_valid}, 32'd0);
        ctrl8 = 1'b1;
        tick();
        model_word(w);
        check("inj_word", {24'd0, d8_data}, {24'd0, w ^ 8'h80});
        tick();
        model_word(w);
        check("inj_after", {24'd0, d8_data}, {24'd0, w});
        i_inj_err = 1'b1;
        tick();
        i_inj_err = 1'b0;
        model_word(w);
        check("inj_coincide", {24'd0, d8_data}, {24'd0, w ^ 8'h80});
        tick();
        ctrl8 = 1'b0;
        model_word(w);
        check("inj_cleared", {24'd0, d8_data}, {24'd0, w});

        // Mode change while enabled is ignored until a disabled cycle.
        i_en = 1'b0; i_mode = 3'd1;
        tick();
        i_en = 1'b1; i_mode = 3'd4; ctrl8 = 1'b1;
        tick();
        ctrl8 = 1'b0;
        check("mode_ignored", {24'd0, d8_data}, 32'h0000_002A);
        i_en = 1'b0;
        tick();
        i_en = 1'b1; ctrl8 = 1'b1;
        tick();
        check("p31_w0", {24'd0, d8_data}, 32'h0000_0000);
        tick();
        check("p31_w1", {24'd0, d8_data}, 32'h0000_0000);
        tick();
        check("p31_w2", {24'd0, d8_data}, 32'h0000_0000);
        tick();
        ctrl8 = 1'b0;
        check("p31_w3", {24'd0, d8_data}, 32'h0000_00AA);

        // Reserved mode code behaves as PRBS9.
        i_en = 1'b0; i_mode = 3'd7;
        tick();
        i_en = 1'b1; ctrl8 = 1'b1;
        tick();
        ctrl8 = 1'b0;
        check("mode7_p9", {24'd0, d8_data}, 32'h0000_002A);

        // Counter wrap with CNT_W=4, then reset mid-stream.
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0; i_mode = 3'd4;
        ctrl8 = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        check("c4_wrap", {28'd0, c4_cnt}, 32'd1);
        check("c32_cnt", d8_cnt, 32'd17);
        i_reset = 1'b1;
        tick();
        check("mid_rst_data", {24'd0, d8_data}, 32'd0);
        check("mid_rst_valid", {31'd0, d8_valid}, 32'd0);
        check("mid_rst_cnt", d8_cnt, 32'd0);
        check("mid_rst_c4", {28'd0, c4_cnt}, 32'd0);
        i_reset = 1'b0;
        tick();
        check("restart_w0", {24'd0, d8_data}, 32'h0000_00FF);
        tick();
        ctrl8 = 1'b0;
        check("restart_w1", {24'd0, d8_data}, 32'h0000_0083);
        tick();
        check("restart_idle", {31'd0, d8_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
